// File: rtl/fifo_40bit_stream_reader.sv
// fifo_40bit_stream_reader: turns a registered-read FIFO (re/empty) into a
// valid/ready stream through a 3-entry prefetch buffer; counts handshakes.
//   clk, rst (async, active-low), clr (sync flush, shared with the FIFO)
//   fifo_dout/fifo_empty in, fifo_re out      : FIFO read side
//   m_data/m_valid out, m_ready in            : stream side
//   xfer_cnt out                              : completed handshakes mod 2^cw
module fifo_40bit_stream_reader #(
   parameter int dw = 40,
   parameter int cw = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic [dw-1:0] fifo_dout,
   input  logic          fifo_empty,
   output logic          fifo_re,
   output logic [dw-1:0] m_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [cw-1:0] xfer_cnt
);

   logic [dw-1:0] buf_q [3];
   logic [1:0]    head_q, head_d;
   logic [1:0]    tail_q, tail_d;
   logic [1:0]    occ_q, occ_d;
   logic          infl_q;
   logic [cw-1:0] cnt_q, cnt_d;
   logic          cap;
   logic          pop;
   logic [2:0]    pend;

   function automatic logic [1:0] inc3(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // buffered plus in-flight words; a new read only if a slot is free
   assign pend    = {1'b0, occ_q} + {2'b0, infl_q};
   assign fifo_re = rst & ~fifo_empty & ~clr & (pend < 3'd3);

   assign m_valid  = (occ_q != 2'd0);
   assign xfer_cnt = cnt_q;

   always_comb begin
      m_data = buf_q[0];
      unique case (head_q)
         2'd1:    m_data = buf_q[1];
         2'd2:    m_data = buf_q[2];
         default: m_data = buf_q[0];
      endcase
   end

   // clr wins over both capture and pop
   assign cap = infl_q & ~clr;
   assign pop = m_valid & m_ready & ~clr;

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      occ_d  = occ_q;
      cnt_d  = cnt_q;
      if (clr) begin
         head_d = 2'd0;
         tail_d = 2'd0;
         occ_d  = 2'd0;
      end else begin
         if (cap) tail_d = inc3(tail_q);
         if (pop) head_d = inc3(head_q);
         occ_d = occ_q + {1'b0, cap} - {1'b0, pop};
      end
      if (pop) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q <= 2'd0;
         tail_q <= 2'd0;
         occ_q  <= 2'd0;
         infl_q <= 1'b0;
         cnt_q  <= '0;
         for (int i = 0; i < 3; i++) buf_q[i] <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
         infl_q <= fifo_re;
         cnt_q  <= cnt_d;
         if (cap) buf_q[tail_q] <= fifo_dout;
      end
   end

   a_no_overflow: assert property (
      @(posedge clk) disable iff (!rst) pend <= 3'd3);

endmodule

// File: tb/tb_fifo_40bit_stream_reader.sv
// tb_fifo_40bit_stream_reader: directed bench with a behavioural
// 1-cycle-latency FIFO in front of the reader.
module tb_fifo_40bit_stream_reader;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        clr = 1'b0;
   logic [39:0] fifo_dout = '0;
   logic        fempty = 1'b1;
   logic        fifo_re;
   logic [39:0] m_data;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic [15:0] xfer_cnt;

   logic        push_v = 1'b0;
   logic [39:0] push_w = '0;
   logic [39:0] fq [$];
   logic [39:0] outq [$];
   int          re_bad = 0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fifo_40bit_stream_reader #(.dw(40), .cw(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .fifo_dout  (fifo_dout),
      .fifo_empty (fempty),
      .fifo_re    (fifo_re),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .xfer_cnt   (xfer_cnt)
   );

   // FIFO model: registered read data, combinational-looking empty flag
   always @(posedge clk) begin
      if (clr) fq.delete();
      else if (fifo_re && fq.size() != 0) fifo_dout <= fq.pop_front();
      if (push_v) fq.push_back(push_w);
      fempty <= (fq.size() == 0);
   end

   // stream monitor, sampled mid-cycle
   always @(negedge clk) begin
      #2;
      if (rst && m_valid && m_ready && !clr) outq.push_back(m_data);
      if (fifo_re && fempty) re_bad++;
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int base, first, last, nre, bad, n;

      // 1: reset with empty FIFO
      repeat (3) @(negedge clk);
      chk("rst_valid", 64'(m_valid), 0);
      chk("rst_data", 64'(m_data), 0);
      rst = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("t1_valid", 64'(m_valid), 0);
         chk("t1_re", 64'(fifo_re), 0);
         chk("t1_cnt", 64'(xfer_cnt), 0);
      end

      // 2: single word latency
      @(negedge clk);
      m_ready = 1'b1; push_v = 1'b1; push_w = 40'h00_0000_00A5;
      @(negedge clk);
      push_v = 1'b0;
      chk("t2_re", 64'(fifo_re), 1);
      chk("t2_v_c0", 64'(m_valid), 0);
      @(negedge clk);
      chk("t2_v_c1", 64'(m_valid), 0);
      @(negedge clk);
      chk("t2_v_c2", 64'(m_valid), 1);
      chk("t2_data", 64'(m_data), 64'h00_0000_00A5);
      @(negedge clk);
      chk("t2_cnt", 64'(xfer_cnt), 1);
      chk("t2_v_end", 64'(m_valid), 0);

      // 3: 512 words, back to back
      base = outq.size(); first = -1; last = -1;
      for (int k = 0; k < 520; k++) begin
         @(negedge clk);
         if (m_valid) begin
            if (first < 0) first = k;
            last = k;
         end
         if (k < 512) begin push_v = 1'b1; push_w = 40'(k); end
         else push_v = 1'b0;
      end
      chk("t3_first", 64'(first), 3);
      chk("t3_span", 64'(last - first + 1), 512);
      chk("t3_count", 64'(outq.size() - base), 512);
      bad = 0;
      for (int i = 0; i < 512 && base + i < outq.size(); i++)
         if (outq[base + i] !== 40'(i)) bad++;
      chk("t3_order", 64'(bad), 0);
      chk("t3_cnt", 64'(xfer_cnt), 513);

      // 4: stalled consumer, 8 words
      base = outq.size(); nre = 0;
      m_ready = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (fifo_re) nre++;
         if (k < 8) begin push_v = 1'b1; push_w = 40'(100 + k); end
         else push_v = 1'b0;
      end
      chk("t4_reads", 64'(nre), 3);
      chk("t4_re_off", 64'(fifo_re), 0);
      chk("t4_valid", 64'(m_valid), 1);
      chk("t4_hold", 64'(m_data), 100);
      chk("t4_none", 64'(outq.size() - base), 0);
      m_ready = 1'b1;
      repeat (20) @(negedge clk);
      chk("t4_count", 64'(outq.size() - base), 8);
      bad = 0;
      for (int i = 0; i < 8 && base + i < outq.size(); i++)
         if (outq[base + i] !== 40'(100 + i)) bad++;
      chk("t4_order", 64'(bad), 0);
      chk("t4_cnt", 64'(xfer_cnt), 521);

      // 5: random ready over 2000 words
      base = outq.size();
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         m_ready = 1'($urandom_range(0, 1));
         push_v = 1'b1;
         push_w = 40'(k) ^ 40'h5A_A5C3_0000;
      end
      @(negedge clk);
      push_v = 1'b0;
      n = 0;
      while (outq.size() - base < 2000 && n < 6000) begin
         @(negedge clk);
         m_ready = 1'($urandom_range(0, 1));
         n++;
      end
      chk("t5_count", 64'(outq.size() - base), 2000);
      bad = 0;
      for (int i = 0; i < 2000 && base + i < outq.size(); i++)
         if (outq[base + i] !== (40'(i) ^ 40'h5A_A5C3_0000)) bad++;
      chk("t5_order", 64'(bad), 0);
      chk("t5_re_empty", 64'(re_bad), 0);
      chk("t5_cnt", 64'(xfer_cnt), 2521);

      // 6: clr with two buffered and one in flight
      @(negedge clk);
      m_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) @(negedge clk);
         push_v = 1'b1; push_w = 40'hC0 + 40'(k);
      end
      @(negedge clk);
      push_v = 1'b0;
      chk("t6_valid_pre", 64'(m_valid), 1);
      chk("t6_data_pre", 64'(m_data), 64'hC0);
      chk("t6_infl", 64'(dut.infl_q), 1);
      chk("t6_occ", 64'(dut.occ_q), 2);
      clr = 1'b1;
      #1;
      chk("t6_re_clr", 64'(fifo_re), 0);
      @(negedge clk);
      clr = 1'b0;
      chk("t6_valid_post", 64'(m_valid), 0);
      chk("t6_cnt_kept", 64'(xfer_cnt), 2521);
      base = outq.size();
      push_v = 1'b1; push_w = 40'h12_3456_7890; m_ready = 1'b1;
      @(negedge clk);
      push_v = 1'b0;
      n = 0;
      while (outq.size() == base && n < 20) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
      chk("t6_count", 64'(outq.size() - base), 1);
      if (outq.size() > base)
         chk("t6_first", 64'(outq[base]), 64'h12_3456_7890);
      else
         chk("t6_first", 64'(0), 64'h12_3456_7890);
      chk("t6_cnt", 64'(xfer_cnt), 2522);
      chk("t6_re_empty", 64'(re_bad), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
